// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit: credit-limited instruction fetch with redirect flush and
// an in-order instruction buffer. Optional macro: IFU_MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int              C_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              C_CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [C_CW:0]   C_DEPTH = (C_CW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e          state_q;
  logic            fetch_fault_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     resp_pc_q;
  logic [C_CW-1:0] outstanding_q;
  logic [C_CW-1:0] outstanding_d;
  logic [C_CW-1:0] drop_cnt_q;
  logic [C_CW-1:0] count_q;
  logic [C_CW-1:0] count_d;
  logic [C_AW-1:0] rd_ptr_q;
  logic [C_AW-1:0] wr_ptr_q;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     pc_q   [FIFO_DEPTH];

  logic [31:0]     w_target;
  logic            w_misalign;
  logic [C_CW:0]   w_inflight;
  logic            w_req_fire;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;

`ifdef IFU_MISALIGN_TRAP_EN
  assign w_target   = redirect_pc;
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign w_target   = redirect_pc & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
`endif

  // Outstanding requests include ones that will be dropped, so the credit
  // check stays conservative across redirects.
  assign w_inflight     = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = rst && (state_q == ST_RUN) && !redirect_valid
                          && (w_inflight < C_DEPTH);
  assign imem_req_addr  = fetch_pc_q;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign fetch_fault = fetch_fault_q;

  assign w_pop  = instr_valid && instr_ready;
  assign w_drop = imem_resp_valid && !redirect_valid && (drop_cnt_q != '0);
  assign w_push = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0)
                  && (state_q == ST_RUN);

  assign outstanding_d = outstanding_q + C_CW'(w_req_fire) - C_CW'(imem_resp_valid);
  assign count_d       = count_q + C_CW'(w_push) - C_CW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      fetch_fault_q <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc_q <= w_target;
        resp_pc_q  <= w_target;
        drop_cnt_q <= outstanding_d;
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        if (w_misalign) begin
          state_q       <= ST_FAULT;
          fetch_fault_q <= 1'b1;
        end else begin
          state_q       <= ST_RUN;
          fetch_fault_q <= 1'b0;
        end
      end else begin
        if (w_req_fire) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (w_drop) begin
          drop_cnt_q <= drop_cnt_q - C_CW'(1);
        end
        if (w_push) begin
          data_q[wr_ptr_q] <= imem_resp_data;
          pc_q[wr_ptr_q]   <= resp_pc_q;
          wr_ptr_q         <= wr_ptr_q + C_AW'(1);
          resp_pc_q        <= resp_pc_q + 32'd4;
        end
        if (w_pop) begin
          rd_ptr_q <= rd_ptr_q + C_AW'(1);
        end
        count_q <= count_d;
      end
    end
  end

  a_resp_has_request: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (outstanding_q != '0));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table from reset, then random
// traffic against a queue/epoch model of the fetch path.
`default_nettype none

module tb_instr_fetch_unit;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] epoch; } mreq_t;
  typedef struct packed { logic [31:0] pc;   logic [31:0] data;  } ent_t;
  typedef struct {
    bit rv; logic [31:0] rpc; bit irdy; bit resp_en;
    bit e_rv; logic [31:0] e_addr; bit e_iv; logic [31:0] e_pc; bit e_fault;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mreq_t       mem_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_epoch = 32'd0;
  bit          m_fault;
  bit          c_rv, c_rdy, c_irdy, c_resp;
  logic [31:0] c_rpc;
  vec_t        vt[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rv, logic [31:0] rpc, bit irdy, bit resp_en,
                              bit e_rv, logic [31:0] e_addr, bit e_iv,
                              logic [31:0] e_pc, bit e_fault);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.irdy = irdy; v.resp_en = resp_en;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic model_reset();
    mem_q.delete();
    fifo_q.delete();
    m_fetch = RST_PC;
    m_fault = 1'b0;
    m_epoch++;
  endtask

  // Memory answers the oldest outstanding request, at least one cycle later.
  task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy,
                       input bit irdy, input bit resp_en);
    c_rv = rv; c_rpc = rpc; c_rdy = rdy; c_irdy = irdy;
    c_resp = resp_en && (mem_q.size() != 0);
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    instr_ready     = irdy;
    imem_resp_valid = c_resp;
    imem_resp_data  = c_resp ? word_of(mem_q[0].addr) : $urandom();
  endtask

  task automatic model_cycle();
    bit    ev;
    mreq_t h;
    ev = !m_fault && !c_rv && ((mem_q.size() + fifo_q.size()) < DEPTH);
    chk_bit("req_valid", imem_req_valid, ev);
    if (ev) chk("req_addr", imem_req_addr, m_fetch);
    chk_bit("instr_valid", instr_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("instr_pc", instr_pc, fifo_q[0].pc);
      chk("instr", instr, fifo_q[0].data);
    end
    chk_bit("fetch_fault", fetch_fault, m_fault);
    if (c_irdy && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (c_resp) begin
      h = mem_q.pop_front();
      if (!c_rv && !m_fault && h.epoch == m_epoch)
        fifo_q.push_back({h.addr, word_of(h.addr)});
    end
    if (c_rv) begin
      fifo_q.delete();
      m_epoch++;
`ifdef IFU_MISALIGN_TRAP_EN
      m_fault = (c_rpc[1:0] != 2'b00);
      m_fetch = c_rpc;
`else
      m_fetch = {c_rpc[31:2], 2'b00};
`endif
    end else if (ev && c_rdy) begin
      mem_q.push_back({m_fetch, m_epoch});
      m_fetch = m_fetch + 32'd4;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    instr_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(negedge clk);
    chk_bit("rst_req_valid", imem_req_valid, 1'b0);
    chk_bit("rst_instr_valid", instr_valid, 1'b0);
    chk_bit("rst_fetch_fault", fetch_fault, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    vec_t        v;
    bit          rv;
    logic [31:0] rpc;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    //          rv  rpc            irdy resp | e_rv e_addr        e_iv e_pc          e_fault
    vt.push_back(mk(0, 32'h0,        0, 1,     1, 32'h0,         0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        0, 1,     1, 32'h4,         0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        0, 1,     0, 32'h0,         1, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        0, 1,     0, 32'h0,         1, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         1, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h8,         1, 32'h4,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'hC,         0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         1, 32'h8,         0));
    vt.push_back(mk(0, 32'h0,        1, 0,     1, 32'h10,        1, 32'hC,         0));
    vt.push_back(mk(0, 32'h0,        1, 0,     1, 32'h14,        0, 32'h0,         0));
    vt.push_back(mk(1, 32'h100,      1, 0,     0, 32'h0,         0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h100,       0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h104,       0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         1, 32'h100,       0));
    vt.push_back(mk(0, 32'h0,        0, 1,     1, 32'h108,       1, 32'h104,       0));
    vt.push_back(mk(1, 32'h200,      1, 1,     0, 32'h0,         1, 32'h104,       0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h200,       0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h204,       0, 32'h0,         0));
    vt.push_back(mk(1, 32'hFFFF_FFFC,1, 1,     0, 32'h0,         1, 32'h200,       0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'hFFFF_FFFC, 0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h0,         0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         1, 32'hFFFF_FFFC, 0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h4,         1, 32'h0,         0));
    vt.push_back(mk(1, 32'h102,      1, 1,     0, 32'h0,         0, 32'h0,         0));
`ifdef IFU_MISALIGN_TRAP_EN
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         0, 32'h0,         1));
    vt.push_back(mk(1, 32'h200,      1, 1,     0, 32'h0,         0, 32'h0,         1));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h200,       0, 32'h0,         0));
`else
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h100,       0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     1, 32'h104,       0, 32'h0,         0));
    vt.push_back(mk(0, 32'h0,        1, 1,     0, 32'h0,         1, 32'h100,       0));
`endif

    foreach (vt[i]) begin
      v = vt[i];
      drive(v.rv, v.rpc, 1'b1, v.irdy, v.resp_en);
      @(negedge clk);
      chk_bit("tv_req_valid", imem_req_valid, v.e_rv);
      if (v.e_rv) chk("tv_req_addr", imem_req_addr, v.e_addr);
      chk_bit("tv_instr_valid", instr_valid, v.e_iv);
      if (v.e_iv) begin
        chk("tv_instr_pc", instr_pc, v.e_pc);
        chk("tv_instr", instr, word_of(v.e_pc));
      end
      chk_bit("tv_fetch_fault", fetch_fault, v.e_fault);
      model_cycle();
      @(posedge clk); #1;
    end

    for (int n = 0; n < 3000; n++) begin
      if (n == 1000 || n == 2000) do_reset();
      rv = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = $urandom();
        default: rpc = $urandom() & 32'hFFFF_FFFC;
      endcase
      drive(rv, rpc, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      @(negedge clk);
      model_cycle();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
